// File: rtl/sm_rocc_ctrl.sv
// sm_rocc_ctrl -- RoCC command controller for a single-operand accelerator.
//
// Accepts one packed RoCC command at a time, launches the accelerator with a
// one-cycle go pulse, waits for completion under a timeout, and for commands
// with xd set returns a packed {rd, data} response.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   cmd_msg/cmd_val/cmd_rdy  command in: {rs1, funct, rs2, rs1_idx, xd, xs1,
//                            xs2, rd, opcode}
//   acc_go                   one-cycle start pulse to the accelerator
//   acc_funct, acc_operand   funct and rs1 of the current command
//   acc_done, acc_result     accelerator completion and result (WAIT only)
//   resp_msg/resp_val/resp_rdy  response out: {rd, data}
//   busy                     high whenever not IDLE
//   err_count                saturating count of timeouts
module sm_rocc_ctrl #(
  parameter int p_rs1bits      = 32,
  parameter int p_rd_data_bits = 32,
  parameter int p_timeout      = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [p_rs1bits+31:0]       cmd_msg,
  input  logic                        cmd_val,
  output logic                        cmd_rdy,
  output logic                        acc_go,
  output logic [6:0]                  acc_funct,
  output logic [p_rs1bits-1:0]        acc_operand,
  input  logic                        acc_done,
  input  logic [p_rd_data_bits-1:0]   acc_result,
  output logic [p_rd_data_bits+4:0]   resp_msg,
  output logic                        resp_val,
  input  logic                        resp_rdy,
  output logic                        busy,
  output logic [7:0]                  err_count
);

  localparam int             CW     = $clog2(p_timeout + 1);
  localparam logic [CW-1:0]  TO_VAL = CW'(p_timeout);

  typedef enum logic [1:0] {S_IDLE, S_GO, S_WAIT, S_RESP} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [6:0]                  funct_q;
  logic [p_rs1bits-1:0]        rs1_q;
  logic [4:0]                  rd_q;
  logic                        xd_q;
  logic [p_rd_data_bits-1:0]   data_q, data_d;
  logic [p_rd_data_bits+4:0]   resp_q, resp_d;
  logic [7:0]                  err_q, err_d;
  logic                        accept;
  logic                        wait_exit;

  // Opcode, rs2, rs1_idx, xs1 and xs2 play no part in execution.
  logic unused_fields;
  assign unused_fields = ^{cmd_msg[24:15], cmd_msg[13:12], cmd_msg[6:0]};

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    resp_d    = resp_q;
    err_d     = err_q;
    accept    = 1'b0;
    wait_exit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_val) begin
          accept  = 1'b1;
          state_d = S_GO;
        end
      end
      S_GO: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (acc_done) begin
          data_d    = acc_result;
          wait_exit = 1'b1;
        end else if (cnt_q == TO_VAL) begin
          data_d    = '1;
          wait_exit = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (wait_exit) begin
          if (xd_q) begin
            state_d = S_RESP;
            // The response register only loads here, so resp_msg is frozen
            // for the whole RESP stay and between commands.
            resp_d  = {rd_q, data_d};
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RESP: begin
        if (resp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state, including the captured command fields and response
  // register, is cleared by reset so outputs are defined from the first cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      funct_q <= '0;
      rs1_q   <= '0;
      rd_q    <= '0;
      xd_q    <= 1'b0;
      data_q  <= '0;
      resp_q  <= '0;
      err_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      if (accept) begin
        rs1_q   <= cmd_msg[p_rs1bits+31:32];
        funct_q <= cmd_msg[31:25];
        xd_q    <= cmd_msg[14];
        rd_q    <= cmd_msg[11:7];
      end
    end
  end

  assign cmd_rdy     = (state_q == S_IDLE);
  assign acc_go      = (state_q == S_GO);
  assign resp_val    = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign acc_funct   = funct_q;
  assign acc_operand = rs1_q;
  assign resp_msg    = resp_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_sm_rocc_ctrl.sv
// Testbench for sm_rocc_ctrl with a 4-cycle timeout. Each command is
// predicted from the controller's rules: number of WAIT cycles, whether it
// times out, the response value and the running timeout count.
module tb_sm_rocc_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] cmd_msg = '0;
  logic        cmd_val = 1'b0;
  logic        cmd_rdy;
  logic        acc_go;
  logic [6:0]  acc_funct;
  logic [31:0] acc_operand;
  logic        acc_done = 1'b0;
  logic [31:0] acc_result = '0;
  logic [36:0] resp_msg;
  logic        resp_val;
  logic        resp_rdy = 1'b0;
  logic        busy;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;
  int err_model = 0;

  sm_rocc_ctrl #(.p_rs1bits(32), .p_rd_data_bits(32), .p_timeout(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_msg(cmd_msg), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .acc_go(acc_go), .acc_funct(acc_funct), .acc_operand(acc_operand),
    .acc_done(acc_done), .acc_result(acc_result),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Runs one command. Entered and left just after a falling edge.
  // done_at: WAIT cycle (1-based) in which acc_done is raised; values outside
  // 1..TO+1 mean the accelerator never answers in time.
  task automatic run_cmd(input logic [6:0] funct, input logic [31:0] rs1,
                         input logic [4:0] rd, input logic xd,
                         input int done_at, input logic [31:0] result,
                         input int stall, input string tag);
    logic        timed_out;
    int          n_wait;
    logic [36:0] exp_msg;
    timed_out = (done_at < 1) || (done_at > TO + 1);
    n_wait    = timed_out ? TO + 1 : done_at;
    exp_msg   = {rd, (timed_out ? 32'hFFFF_FFFF : result)};
    if (timed_out && err_model < 255) err_model++;

    total++;
    if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_before: cmd_rdy=%b busy=%b need 1 0", tag, cmd_rdy, busy);
    end
    cmd_msg = {rs1, funct, 5'($urandom), 5'($urandom), xd, 2'($urandom), rd, 7'($urandom)};
    cmd_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Cycle 1: GO. Garbage commands and a stray done here must be ignored.
    cmd_val  = 1'($urandom);
    cmd_msg  = {$urandom, $urandom};
    acc_done = 1'($urandom);
    acc_result = $urandom;
    total++;
    if (acc_go !== 1'b1 || acc_funct !== funct || acc_operand !== rs1 ||
        busy !== 1'b1 || cmd_rdy !== 1'b0) begin
      bad++;
      $display("FAIL %s go_cycle: go=%b funct=%h op=%h busy=%b rdy=%b need 1 %h %h 1 0",
               tag, acc_go, acc_funct, acc_operand, busy, cmd_rdy, funct, rs1);
    end
    for (int w = 1; w <= n_wait; w++) begin
      @(negedge clk);
      total++;
      if (acc_go !== 1'b0 || busy !== 1'b1 || cmd_rdy !== 1'b0 || resp_val !== 1'b0 ||
          acc_funct !== funct || acc_operand !== rs1) begin
        bad++;
        $display("FAIL %s wait%0d: go=%b busy=%b rdy=%b rval=%b funct=%h op=%h need 0 1 0 0 %h %h",
                 tag, w, acc_go, busy, cmd_rdy, resp_val, acc_funct, acc_operand, funct, rs1);
      end
      acc_done   = (w == done_at);
      acc_result = (w == done_at) ? result : $urandom;
      cmd_val    = 1'($urandom);
    end
    @(negedge clk);
    acc_done = 1'($urandom);
    if (xd) begin
      for (int s = 0; s <= stall; s++) begin
        total++;
        if (resp_val !== 1'b1 || resp_msg !== exp_msg || cmd_rdy !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s resp%0d: rval=%b msg=%h rdy=%b busy=%b need 1 %h 0 1",
                   tag, s, resp_val, resp_msg, cmd_rdy, busy, exp_msg);
        end
        resp_rdy = (s == stall);
        cmd_val  = 1'($urandom);
        @(negedge clk);
      end
      resp_rdy = 1'b0;
    end
    cmd_val  = 1'b0;
    acc_done = 1'b0;
    total++;
    if (cmd_rdy !== 1'b1 || busy !== 1'b0 || resp_val !== 1'b0 ||
        err_count !== 8'(err_model) || acc_funct !== funct || acc_operand !== rs1) begin
      bad++;
      $display("FAIL %s after: rdy=%b busy=%b rval=%b err=%0d funct=%h op=%h need 1 0 0 %0d %h %h",
               tag, cmd_rdy, busy, resp_val, err_count, acc_funct, acc_operand,
               err_model, funct, rs1);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (cmd_rdy !== 1'b1 || acc_go !== 1'b0 || resp_val !== 1'b0 || busy !== 1'b0 ||
        resp_msg !== 37'h0 || err_count !== 8'h0 || acc_funct !== 7'h0 || acc_operand !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b go=%b rval=%b busy=%b msg=%h err=%0d funct=%h op=%h need 1 0 0 0 0 0 0 0",
               cmd_rdy, acc_go, resp_val, busy, resp_msg, err_count, acc_funct, acc_operand);
    end
    @(negedge clk);
    reset_n = 1'b1;
    err_model = 0;
  endtask

  // Issued right on reset release: the first edge after release accepts it.
  task automatic test_basic();
    run_cmd(7'h05, 32'hDEAD_BEEF, 5'd3, 1'b1, 1, 32'h0000_1234, 0, "basic");
  endtask

  task automatic test_no_resp();
    run_cmd(7'h11, 32'h0BAD_F00D, 5'd9, 1'b0, 4, 32'hCAFE_0001, 0, "no_resp");
  endtask

  task automatic test_backpressure();
    run_cmd(7'h2A, 32'h1357_9BDF, 5'd17, 1'b1, 2, 32'h89AB_CDEF, 5, "backpressure");
  endtask

  task automatic test_timeout();
    run_cmd(7'h33, 32'h5555_AAAA, 5'd21, 1'b1, 0, 32'h0, 1, "timeout");
    total++;
    if (err_count !== 8'd1) begin
      bad++;
      $display("FAIL timeout_count: err=%0d need 1", err_count);
    end
  endtask

  task automatic test_collision();
    run_cmd(7'h44, 32'h0F0F_0F0F, 5'd30, 1'b1, TO + 1, 32'h7777_1111, 0, "collision");
  endtask

  task automatic test_stray_done();
    for (int i = 0; i < 3; i++) begin
      acc_done   = 1'b1;
      acc_result = $urandom;
      @(negedge clk);
      total++;
      if (cmd_rdy !== 1'b1 || busy !== 1'b0 || acc_go !== 1'b0 || resp_val !== 1'b0 ||
          err_count !== 8'(err_model)) begin
        bad++;
        $display("FAIL stray_done%0d: rdy=%b busy=%b go=%b rval=%b err=%0d need 1 0 0 0 %0d",
                 i, cmd_rdy, busy, acc_go, resp_val, err_count, err_model);
      end
    end
    acc_done = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_cmd(7'($urandom), $urandom, 5'($urandom), 1'($urandom),
              $urandom_range(0, TO + 2), $urandom, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid();
    cmd_msg = {32'hABCD_0123, 7'h19, 5'd0, 5'd0, 1'b1, 2'b00, 5'd7, 7'h0B};
    cmd_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    err_model = 0;
    total++;
    if (busy !== 1'b0 || cmd_rdy !== 1'b1 || acc_go !== 1'b0 || resp_val !== 1'b0 ||
        err_count !== 8'h0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b rdy=%b go=%b rval=%b err=%0d need 0 1 0 0 0",
               busy, cmd_rdy, acc_go, resp_val, err_count);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    resp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (resp_val !== 1'b0 || cmd_rdy !== 1'b1 || acc_go !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_after%0d: rval=%b rdy=%b go=%b need 0 1 0",
                 i, resp_val, cmd_rdy, acc_go);
      end
    end
    resp_rdy = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      run_cmd(7'($urandom), $urandom, 5'($urandom), 1'($urandom), 0, 32'h0, 0, "saturate");
    end
    total++;
    if (err_count !== 8'd255) begin
      bad++;
      $display("FAIL saturate_final: err=%0d need 255", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_resp();
    test_backpressure();
    test_timeout();
    test_collision();
    test_stray_done();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_rocc_ctrl.md
# sm_rocc_ctrl

RoCC command controller for the source/sink message path. It accepts one packed RoCC command at a time over a val/rdy port, decodes it using the standard RoCC field layout, and launches a single-operand accelerator. It waits for completion, bounded by a timeout, and when the command's `xd` bit is set it returns a packed `{rd, data}` response over a val/rdy port. It sits between the RoCC source/sink interfaces and one accelerator datapath.

## Interface
- `p_rs1bits`, 32: width of the rs1 operand carried in the command message.
- `p_rd_data_bits`, 32: width of the response data.
- `p_timeout`, 255: maximum number of WAIT cycles before abort; legal range ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_msg`  in  p_rs1bits+32  `{rs1, funct[31:25], rs2[24:20], rs1_idx[19:15], xd[14], xs1[13], xs2[12], rd[11:7], opcode[6:0]}`.
- `cmd_val`  in  1 / `cmd_rdy`  out  1  command handshake.
- `acc_go`  out  1  one-cycle start pulse to the accelerator.
- `acc_funct`  out  7  registered funct of the current command.
- `acc_operand`  out  p_rs1bits  registered rs1 of the current command.
- `acc_done`  in  1  accelerator completion, sampled in WAIT only.
- `acc_result`  in  p_rd_data_bits  result, valid when `acc_done`=1.
- `resp_msg`  out  5+p_rd_data_bits  `{rd, data}`.
- `resp_val`  out  1 / `resp_rdy`  in  1  response handshake.
- `busy`  out  1  high in every state except IDLE.
- `err_count`  out  8  saturating count of timeouts.

## Operation
- States:
  - IDLE: `cmd_rdy`=1. On `cmd_val`, register funct, rs1, rd and xd, then go to GO.
  - GO: `acc_go`=1 for exactly one cycle. Clear the timeout counter, then go to WAIT.
  - WAIT:
    - If `acc_done`=1, capture `acc_result` into the data register.
    - Otherwise the counter increments. When the counter reaches `p_timeout` with `acc_done`=0, load all-ones into the data register and increment `err_count`.
    - On either exit: if xd=1 go to RESP, else go to IDLE.
  - RESP: `resp_val`=1 and `resp_msg`={rd, data}, held stable until `resp_rdy`=1, then go to IDLE.
- `acc_done` asserted outside WAIT is ignored. `cmd_val` outside IDLE is not accepted.
- `acc_done` in the same cycle the counter reaches `p_timeout`: done wins. The result is captured and `err_count` is unchanged.
- Counter width is clog2(p_timeout+1). It never wraps in WAIT.
- `err_count` saturates at 255.
- Opcode, xs1, xs2, rs2 and rs1_idx are ignored. All commands are executed.
- `acc_funct` and `acc_operand` stay stable from GO until the next command is accepted.

## Timing
- Reset (asynchronous assert, any state): state=IDLE; counter=0; registered funct, rs1, rd, xd and data=0; `err_count`=0.
- Outputs during reset: `cmd_rdy`=1, `acc_go`=0, `resp_val`=0, `busy`=0, `resp_msg`=0.
- Reset asserted mid-command abandons the command. No response is ever issued for it.
- Reset deassertion is taken synchronously. The first command can be accepted on the first edge after deassertion.
- Cycle timeline, with cycle 0 = the edge where the command is accepted:
  - Cycle 1: GO, `acc_go`=1.
  - Cycle 2 onward: WAIT.
  - `acc_done` sampled at the edge ending cycle k puts RESP at cycle k+1 with `resp_val`=1.
  - The response handshake edge returns to IDLE, and `cmd_rdy`=1 in the next cycle.
- Minimum command-to-response latency is 3 cycles (`acc_done` in the first WAIT cycle).
- No back-to-back overlap. Throughput is at most one command per 4 cycles with xd=1, or per 3 cycles with xd=0.
- Timeout: with no `acc_done`, WAIT lasts p_timeout+1 cycles, then the controller exits.
- `resp_msg` changes only on entry to RESP. It holds while `resp_rdy`=0.

## Test plan
- Basic handshake: command funct=7'h05, rs1=32'hDEAD_BEEF, rd=5'd3, xd=1; `acc_done` with `acc_result`=32'h1234 in the first WAIT cycle.
  - Required: `acc_go` one cycle at cycle 1 with `acc_funct`=5 and `acc_operand`=DEADBEEF.
  - Required: `resp_msg`={5'd3, 32'h1234} at cycle 3.
- No response: command with xd=0 and `acc_done` after 4 WAIT cycles. Required: `resp_val` never rises, and `cmd_rdy` returns 1 the cycle after done.
- Backpressure: hold `resp_rdy`=0 for 5 cycles in RESP. Required: `resp_msg` and `resp_val` stable throughout, no new command accepted, then one handshake.
- Timeout: p_timeout=4 and no `acc_done`.
  - Required: exit after 5 WAIT cycles, `resp_msg`={rd, all-ones}, `err_count`=1.
  - Repeat 300 times. Required: `err_count` saturates at 255.
- Done/timeout collision and stray done: p_timeout=4 with `acc_done` on the 5th WAIT cycle. Required: real result returned and `err_count` unchanged. Also pulse `acc_done` in IDLE. Required: ignored.
- Reset mid-operation: assert `reset_n`=0 asynchronously in WAIT. Required: immediately `busy`=0, `cmd_rdy`=1, `acc_go`=0, and no response after release.
